// File: rtl/vxe_txnres_status_arb_pkg.sv
// rtl/vxe_txnres_status_arb_pkg.sv - shared err codes, status vector field offsets and clog2
package vxe_txnres_status_arb_pkg;

   // Response error codes; anything other than ERR_OK is an error
   typedef enum logic [1:0] {
      ERR_OK   = 2'b00,
      ERR_EXOK = 2'b01,
      ERR_SLV  = 2'b10,
      ERR_DEC  = 2'b11
   } txn_err_e;

   // Field offsets inside the {txnid, rnw, err} status vector
   localparam int ERR_LSB   = 0;
   localparam int ERR_W     = 2;
   localparam int RNW_BIT   = 2;
   localparam int TXNID_LSB = 3;

   // Ceiling log2 for sizing pointers and counters
   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

endpackage

// File: rtl/vxe_txnres_fifo.sv
// rtl/vxe_txnres_fifo.sv - generic sync FIFO with registered head and full/empty flags
module vxe_txnres_fifo
   import vxe_txnres_status_arb_pkg::*;
#(
   parameter int WIDTH = 9,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int AW = clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] head_q, head_d;
   logic             valid_q, valid_d;
   logic             do_push, do_pop;

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = ~valid_q;
   assign rdata_o = head_q;
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & valid_q;

   // Next pointers, occupancy and head; a push into the slot that becomes head bypasses the array
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      head_d   = head_q;
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      valid_d = (count_d != '0);
      if (valid_d) begin
         head_d = (do_push && (wr_ptr_q == rd_ptr_d)) ? wdata_i : mem_q[rd_ptr_d];
      end
   end

   // Control and head registers
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         head_q   <= '0;
         valid_q  <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         head_q   <= head_d;
         valid_q  <= valid_d;
      end
   end

   // Storage array, not reset: contents are qualified by the count
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/vxe_txnres_status_arb.sv
// rtl/vxe_txnres_status_arb.sv - round-robin status packer/arbiter; VXE_TXNRES_ERRCNT_EN adds an error counter
module vxe_txnres_status_arb
   import vxe_txnres_status_arb_pkg::*;
#(
   parameter int TXNID_W = 6,
   parameter int NCH     = 2,
   parameter int DEPTH   = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NCH*TXNID_W-1:0] i_txnid,
   input  logic [NCH-1:0]         i_rnw,
   input  logic [NCH*2-1:0]       i_err,
   input  logic [NCH-1:0]         i_valid,
   output logic [NCH-1:0]         o_rdy,
   output logic [TXNID_W+2:0]     o_res_vec_txn,
   output logic                   o_valid,
   input  logic                   i_rdy
`ifdef VXE_TXNRES_ERRCNT_EN
   ,
   input  logic                   i_errcnt_clr,
   output logic [15:0]            o_errcnt
`endif
);

   localparam int VW = TXNID_W + 3;
   localparam int RW = (NCH > 1) ? clog2(NCH) : 1;

   logic [RW-1:0]      rr_q, rr_d, gnt_idx;
   logic               gnt_found;
   logic               fifo_full, fifo_empty;
   logic               push;
   logic [NCH-1:0]     rdy_c;
   logic [TXNID_W-1:0] sel_txnid;
   logic               sel_rnw;
   logic [1:0]         sel_err;
   logic [VW-1:0]      push_vec;

   // First valid channel searching upward from the rr pointer with wrap
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      for (int off = 0; off < NCH; off++) begin
         for (int k = 0; k < NCH; k++) begin
            if (!gnt_found && i_valid[k] && (((int'(rr_q) + off) % NCH) == k)) begin
               gnt_found = 1'b1;
               gnt_idx   = RW'(k);
            end
         end
      end
   end

   // Accept strobe and data mux for the granted channel; nothing is accepted while full
   always_comb begin
      rdy_c     = '0;
      sel_txnid = '0;
      sel_rnw   = 1'b0;
      sel_err   = '0;
      for (int k = 0; k < NCH; k++) begin
         if (gnt_idx == RW'(k)) begin
            sel_txnid = i_txnid[k*TXNID_W +: TXNID_W];
            sel_rnw   = i_rnw[k];
            sel_err   = i_err[2*k +: 2];
            rdy_c[k]  = gnt_found & ~fifo_full;
         end
      end
   end

   // Pack {txnid, rnw, err}; err passes through unmodified
   always_comb begin
      push_vec                         = '0;
      push_vec[TXNID_LSB +: TXNID_W]   = sel_txnid;
      push_vec[RNW_BIT]                = sel_rnw;
      push_vec[ERR_LSB +: ERR_W]       = sel_err;
   end

   assign push  = |rdy_c;
   assign o_rdy = rdy_c;

   // Pointer moves past the winner; holds without a grant
   always_comb begin
      rr_d = rr_q;
      if (push) rr_d = (int'(gnt_idx) == NCH - 1) ? '0 : gnt_idx + RW'(1);
   end

   // Round-robin pointer register
   always_ff @(posedge clk) begin
      if (rst) rr_q <= '0;
      else     rr_q <= rr_d;
   end

   vxe_txnres_fifo #(
      .WIDTH (VW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push),
      .wdata_i (push_vec),
      .pop_i   (i_rdy),
      .rdata_o (o_res_vec_txn),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign o_valid = ~fifo_empty;

`ifdef VXE_TXNRES_ERRCNT_EN
   logic [15:0] errcnt_q, errcnt_d;

   // Saturating count of accepted error responses; clear wins over an increment
   always_comb begin
      errcnt_d = errcnt_q;
      if (i_errcnt_clr) errcnt_d = '0;
      else if (push && (sel_err != ERR_OK) && (errcnt_q != 16'hFFFF)) errcnt_d = errcnt_q + 16'd1;
   end

   // Error counter register
   always_ff @(posedge clk) begin
      if (rst) errcnt_q <= '0;
      else     errcnt_q <= errcnt_d;
   end

   assign o_errcnt = errcnt_q;
`endif

endmodule

// File: tb/tb_vxe_txnres_status_arb.sv
// tb/tb_vxe_txnres_status_arb.sv - randomized self-checking bench with queue-based reference model
module tb_vxe_txnres_status_arb;

   localparam int TXNID_W = 6;
   localparam int NCH     = 2;
   localparam int DEPTH   = 4;
   localparam int VW      = TXNID_W + 3;

   logic                   clk = 1'b0;
   logic                   rst;
   logic [NCH*TXNID_W-1:0] i_txnid;
   logic [NCH-1:0]         i_rnw;
   logic [NCH*2-1:0]       i_err;
   logic [NCH-1:0]         i_valid;
   logic [NCH-1:0]         o_rdy;
   logic [VW-1:0]          o_res_vec_txn;
   logic                   o_valid;
   logic                   i_rdy;
`ifdef VXE_TXNRES_ERRCNT_EN
   logic                   i_errcnt_clr;
   logic [15:0]            o_errcnt;
`endif

   always #5 clk = ~clk;

   vxe_txnres_status_arb #(
      .TXNID_W (TXNID_W),
      .NCH     (NCH),
      .DEPTH   (DEPTH)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .i_txnid       (i_txnid),
      .i_rnw         (i_rnw),
      .i_err         (i_err),
      .i_valid       (i_valid),
      .o_rdy         (o_rdy),
      .o_res_vec_txn (o_res_vec_txn),
      .o_valid       (o_valid),
      .i_rdy         (i_rdy)
`ifdef VXE_TXNRES_ERRCNT_EN
      ,
      .i_errcnt_clr  (i_errcnt_clr),
      .o_errcnt      (o_errcnt)
`endif
   );

   int checks   = 0;
   int failures = 0;

   // Source-side pending request per channel, held until accepted
   bit            pend_v   [NCH];
   logic [VW-1:0] pend_vec [NCH];
   // Reference model: ordered contents of the output buffer, rr pointer, error count
   logic [VW-1:0] model_q [$];
   int            model_rr;
   int            model_errcnt;
   int            n_gen;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic gen(input int ch, input logic [1:0] err);
      logic [TXNID_W-1:0] id;
      id           = TXNID_W'($urandom);
      pend_v[ch]   = 1'b1;
      pend_vec[ch] = {id, 1'($urandom), err};
   endtask

   task automatic set_req(input int ch, input logic [VW-1:0] vec);
      pend_v[ch]   = 1'b1;
      pend_vec[ch] = vec;
   endtask

   // One clock: drive, check outputs against the model, advance the model, wait for next negedge
   task automatic cycle(input bit rdy, input bit clr);
      int g;
      int c;
      logic [NCH-1:0] exp_rdy;
      i_rdy = rdy;
`ifdef VXE_TXNRES_ERRCNT_EN
      i_errcnt_clr = clr;
`endif
      for (int k = 0; k < NCH; k++) begin
         i_valid[k]                   = pend_v[k] & ~rst;
         i_txnid[k*TXNID_W +: TXNID_W] = pend_vec[k][VW-1:3];
         i_rnw[k]                     = pend_vec[k][2];
         i_err[2*k +: 2]              = pend_vec[k][1:0];
      end
      #1;
      g = -1;
      if (!rst && model_q.size() < DEPTH) begin
         for (int off = 0; off < NCH; off++) begin
            c = (model_rr + off) % NCH;
            if (g < 0 && pend_v[c]) g = c;
         end
      end
      exp_rdy = '0;
      if (g >= 0) exp_rdy[g] = 1'b1;
      check("o_rdy", 32'(o_rdy), 32'(exp_rdy));
      check("o_valid", 32'(o_valid), 32'(model_q.size() != 0));
      if (model_q.size() != 0) check("o_res_vec_txn", 32'(o_res_vec_txn), 32'(model_q[0]));
`ifdef VXE_TXNRES_ERRCNT_EN
      check("o_errcnt", 32'(o_errcnt), 32'(model_errcnt));
`endif
      if (rst) begin
         model_q.delete();
         model_rr     = 0;
         model_errcnt = 0;
      end else begin
         if (model_q.size() != 0 && rdy) void'(model_q.pop_front());
         if (g >= 0) begin
            model_q.push_back(pend_vec[g]);
            pend_v[g] = 1'b0;
            model_rr  = (g + 1) % NCH;
            if (pend_vec[g][1:0] != 2'b00 && model_errcnt < 16'hFFFF) model_errcnt++;
         end
         if (clr) model_errcnt = 0;
      end
      @(negedge clk);
   endtask

   initial begin
      rst          = 1'b1;
      i_txnid      = '0;
      i_rnw        = '0;
      i_err        = '0;
      i_valid      = '0;
      i_rdy        = 1'b0;
`ifdef VXE_TXNRES_ERRCNT_EN
      i_errcnt_clr = 1'b0;
`endif
      for (int k = 0; k < NCH; k++) begin
         pend_v[k]   = 1'b0;
         pend_vec[k] = '0;
      end
      model_rr     = 0;
      model_errcnt = 0;

      // Reset state
      repeat (2) @(negedge clk);
      #1;
      check("reset_o_valid", 32'(o_valid), 32'd0);
      check("reset_o_rdy", 32'(o_rdy), 32'd0);
`ifdef VXE_TXNRES_ERRCNT_EN
      check("reset_o_errcnt", 32'(o_errcnt), 32'd0);
`endif
      @(negedge clk);
      rst = 1'b0;

      // Single ch0 push, txnid=2A rnw=1 err=0
      set_req(0, 9'h154);
      cycle(1'b1, 1'b0);
      #1;
      check("single_valid", 32'(o_valid), 32'd1);
      check("single_vec", 32'(o_res_vec_txn), 32'h154);
      repeat (3) cycle(1'b1, 1'b0);

      // Both channels continuously valid: alternation checked by the model
      for (int i = 0; i < 10; i++) begin
         for (int k = 0; k < NCH; k++) if (!pend_v[k]) gen(k, 2'($urandom));
         cycle(1'b1, 1'b0);
      end
      while (pend_v[0] || pend_v[1] || model_q.size() != 0) cycle(1'b1, 1'b0);

      // Fill with downstream stalled, 5 requests on ch1
      n_gen = 0;
      for (int i = 0; i < 7; i++) begin
         if (!pend_v[1] && n_gen < 5) begin gen(1, 2'b00); n_gen++; end
         cycle(1'b0, 1'b0);
      end
      #1;
      check("full_no_grant", 32'(o_rdy), 32'd0);
      check("full_pending_5th", 32'(pend_v[1]), 32'd1);
      for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0);

      // Push and pop together at count 2
      gen(0, 2'b00); cycle(1'b0, 1'b0);
      gen(1, 2'b00); cycle(1'b0, 1'b0);
      gen(0, 2'b00); cycle(1'b1, 1'b0);
      check("pushpop_count", 32'(model_q.size()), 32'd2);
      repeat (3) cycle(1'b1, 1'b0);

      // Reset with 3 entries buffered
      for (int i = 0; i < 3; i++) begin gen(i % NCH, 2'b00); cycle(1'b0, 1'b0); end
      rst = 1'b1;
      cycle(1'b1, 1'b0);
      rst = 1'b0;
      #1;
      check("rst_flush_valid", 32'(o_valid), 32'd0);
      repeat (3) cycle(1'b1, 1'b0);

`ifdef VXE_TXNRES_ERRCNT_EN
      // Error counting and clear priority
      rst = 1'b1; cycle(1'b1, 1'b0); rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         gen(0, (i == 3) ? 2'b00 : 2'b10);
         cycle(1'b1, 1'b0);
      end
      #1;
      check("errcnt_three", 32'(o_errcnt), 32'd3);
      gen(0, 2'b10);
      cycle(1'b1, 1'b1);
      #1;
      check("errcnt_clr_wins", 32'(o_errcnt), 32'd0);
`endif

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         for (int k = 0; k < NCH; k++) begin
            if (!pend_v[k] && ($urandom_range(0, 2) != 0))
               gen(k, ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b00);
         end
         rst = ($urandom_range(0, 299) == 0);
         cycle($urandom_range(0, 3) != 0, $urandom_range(0, 99) == 0);
      end
      rst = 1'b0;
      repeat (8) cycle(1'b1, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
